// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - state encoding, constants and key byte select for the RC4 key schedule
package ksa_pkg;

  localparam int KEY_LEN = 3;
  localparam int N       = 256;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    WAIT_I,
    CALC_J,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J
  } state_t;

  // Byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ksa.sv
// rtl/ksa.sv - RC4 key-scheduling engine driving an external 256x8 S memory
module ksa
  import ksa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  state_t     state_q;
  logic [7:0] i_q, j_q, si_q, addr_q, wrdata_q;
  logic [1:0] kidx_q;
  logic       rdy_q, wren_q;

  logic [7:0] i_d, j_d;
  logic [1:0] kidx_d;
  logic       last_iter;

  always_comb begin
    j_d       = j_q + si_q + key_byte(key, kidx_q);
    i_d       = i_q + 8'd1;
    kidx_d    = (kidx_q == 2'(KEY_LEN - 1)) ? 2'd0 : kidx_q + 2'd1;
    last_iter = (i_q == 8'(N - 1));
  end

  // Outputs are registered, so each state loads the bus values of the state it enters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      kidx_q   <= 2'd0;
      si_q     <= 8'd0;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            kidx_q  <= 2'd0;
            addr_q  <= 8'd0;
            rdy_q   <= 1'b0;
            state_q <= RD_I;
          end
        end
        RD_I:   state_q <= WAIT_I;
        WAIT_I: begin
          si_q    <= rddata;
          state_q <= CALC_J;
        end
        CALC_J: begin
          j_q     <= j_d;
          addr_q  <= j_d;
          state_q <= RD_J;
        end
        RD_J:   state_q <= WAIT_J;
        WAIT_J: begin
          addr_q   <= i_q;
          wrdata_q <= rddata;
          wren_q   <= 1'b1;
          state_q  <= WR_I;
        end
        WR_I: begin
          addr_q   <= j_q;
          wrdata_q <= si_q;
          state_q  <= WR_J;
        end
        WR_J: begin
          wren_q <= 1'b0;
          if (last_iter) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            i_q     <= i_d;
            kidx_q  <= kidx_d;
            addr_q  <= i_d;
            state_q <= RD_I;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy    = rdy_q;
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: tb/tb_ksa.sv
// tb/tb_ksa.sv - directed bench for ksa against an external S memory and an RC4 KSA model
module tb_ksa;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  logic        init_mem;

  logic [7:0] mem   [256];
  logic [7:0] exp_a [512];
  logic [7:0] exp_d [512];
  logic [7:0] exp_s [256];

  int n_vec;
  int n_err;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read S memory; init_mem reloads the identity permutation.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] jj, kb, t;
    for (int n = 0; n < 256; n++) s[n] = mem[n];
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? k[23:16] : (n % 3 == 1) ? k[15:8] : k[7:0];
      jj = jj + s[n] + kb;
      exp_a[2*n]   = 8'(n);
      exp_d[2*n]   = s[jj];
      exp_a[2*n+1] = jj;
      exp_d[2*n+1] = s[n];
      t = s[n];
      s[n] = s[jj];
      s[jj] = t;
    end
    for (int n = 0; n < 256; n++) exp_s[n] = s[n];
  endtask

  task automatic load_identity();
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
  endtask

  // mode 0: single en pulse, 1: en toggled during the run, 2: en held high throughout.
  task automatic run_ksa(input logic [23:0] k, input int mode, input bit directed);
    int wcnt;
    int rise;
    int dcyc [4];
    logic [7:0] da [4];
    logic [7:0] dd [4];
    dcyc = '{6, 7, 13, 14};
    da   = '{8'd0, 8'd0, 8'd1, 8'd4};
    dd   = '{8'd0, 8'd0, 8'd4, 8'd1};
    wcnt = 0;
    rise = 0;
    key  = k;
    build_model(k);
    en = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (cyc == 1) check("rdy_low_start", rdy, 1'b0);
      check("wren_phase", wren, ((cyc % 7 == 6) || (cyc % 7 == 0)) && (cyc <= 1792));
      if (directed) begin
        for (int d = 0; d < 4; d++) begin
          if (cyc == dcyc[d]) begin
            check("dir_addr", addr, da[d]);
            check("dir_wrdata", wrdata, dd[d]);
            check("dir_wren", wren, 1'b1);
          end
        end
      end
      if (wren) begin
        if (wcnt < 512) begin
          check("wr_addr", addr, exp_a[wcnt]);
          check("wr_data", wrdata, exp_d[wcnt]);
        end
        wcnt++;
      end
      if (rdy) begin
        rise = cyc;
        break;
      end
      if (mode == 0) en = 1'b0;
      else if (mode == 1) en = (cyc < 1780) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("rdy_rise_cycle", rise, 1793);
    check("write_count", wcnt, 512);
    for (int n = 0; n < 256; n++) check("ram_final", mem[n], exp_s[n]);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    en       = 1'b0;
    key      = 24'h0;
    init_mem = 1'b0;
    @(negedge clk);
    check("reset_rdy", rdy, 1'b1);
    check("reset_wren", wren, 1'b0);
    check("reset_addr", addr, 8'd0);
    check("reset_wrdata", wrdata, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_rdy", rdy, 1'b1);
    check("idle_wren", wren, 1'b0);

    load_identity();
    run_ksa(24'h00033C, 0, 1'b1);

    load_identity();
    run_ksa(24'hA55AFF, 1, 1'b0);

    run_ksa(24'h010203, 2, 1'b0);
    @(negedge clk);
    check("restart_rdy", rdy, 1'b0);
    check("restart_addr", addr, 8'd0);
    check("restart_wren", wren, 1'b0);
    repeat (702) @(negedge clk);
    check("pre_reset_addr", addr, 8'd100);
    rst_n = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    check("midrst_rdy", rdy, 1'b1);
    check("midrst_wren", wren, 1'b0);
    check("midrst_addr", addr, 8'd0);
    check("midrst_wrdata", wrdata, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("post_rst_idle", rdy, 1'b1);
    run_ksa(24'h123456, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
